// File: rtl/serial_addsub_ovf.sv
// serial_addsub_ovf
//   Multi-cycle add/subtract unit. It works on DIGIT bits per clock, LSB
//   first, and takes N = WIDTH/DIGIT RUN cycles. Subtraction is A + ~B + 1:
//   the inverted B and the initial carry are loaded when the operation is
//   accepted. The O/Z/N/C flags are registered on the last RUN edge.
//
// Handshake (valid/ready):
//   - start acts as "valid" and is accepted on any edge where the unit is IDLE
//     or DONE ("ready" = !busy). op, a and b are captured on that edge only.
//   - start while busy is ignored and is not queued.
//   - done pulses for exactly one cycle. result and the flags are valid from
//     that cycle and hold until the next accepted start.
//
// Ports
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    operation request
//   op       0 = a+b, 1 = a-b
//   a, b     operands (WIDTH bits)
//   busy     1 while an operation is running
//   done     one-cycle completion pulse
//   result   sum/difference, modulo 2^WIDTH
//   sig_O    signed overflow
//   sig_Z    result == 0
//   sig_N    result MSB
//   sig_C    carry out of the MSB (for subtract, 1 = no borrow)
//
// Debug: state_q is a named enum register, so checkers can bind to it.

module serial_addsub_ovf #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             sig_O,
  output logic             sig_Z,
  output logic             sig_N,
  output logic             sig_C
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic               op_q, op_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               o_q, o_d;
  logic               z_q, z_d;
  logic               n_q, n_d;
  logic               c_q, c_d;

  // One digit of the ripple add. The extra top bit is the digit carry-out.
  logic [DIGIT:0]       digit_sum;
  // The new digit enters at the MSB end and the old contents move down.
  // This form works even when WIDTH == DIGIT.
  logic [WIDTH+DIGIT-1:0] shift_cat;
  logic [WIDTH-1:0]     res_shift;
  logic                 last_digit;
  logic                 res_msb;

  always_comb begin
    digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
               + {{DIGIT{1'b0}}, cin_q};
    shift_cat  = {digit_sum[DIGIT-1:0], result_q} >> DIGIT;
    res_shift  = shift_cat[WIDTH-1:0];
    last_digit = (cnt_q == CNT_W'(N - 1));
    res_msb    = res_shift[WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    op_d     = op_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    o_d      = o_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = op ? ~b : b;
          cin_d    = op;
          op_d     = op;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          result_d = '0;
          o_d      = 1'b0;
          z_d      = 1'b0;
          n_d      = 1'b0;
          c_d      = 1'b0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        cin_d    = digit_sum[DIGIT];
        result_d = res_shift;
        cnt_d    = cnt_q + 1'b1;
        if (last_digit) begin
          state_d = ST_DONE;
          c_d     = digit_sum[DIGIT];
          n_d     = res_msb;
          z_d     = (res_shift == '0);
          // The overflow test uses the original operand signs. For subtract,
          // b_msb is the sign of b before it was inverted.
          o_d     = op_q ? ((a_msb_q != b_msb_q) && (res_msb != a_msb_q))
                         : ((a_msb_q == b_msb_q) && (res_msb != a_msb_q));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      op_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      o_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      op_q     <= op_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      o_q      <= o_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign sig_O  = o_q;
  assign sig_Z  = z_q;
  assign sig_N  = n_q;
  assign sig_C  = c_q;

endmodule
